// File: rtl/frame_scheduler.sv
// frame_scheduler: double-buffer frame sequencer.
// Clears the back buffer to the sky colour, hands the buffer to the renderer,
// forwards renderer pixel writes, then swaps buffers on the next vsync.
//
// Handshake: render_ack is a one-cycle start pulse to the renderer; render_done
// is a one-cycle completion pulse back. Neither side waits on the other's level.
// fb_we qualifies fb_x/fb_y/fb_color for exactly the cycle it is high.
// The framebuffer port has no backpressure.
module frame_scheduler #(
  parameter logic [2:0] SKY_COLOR = 3'd1,
  parameter bit         CLEAR_EN  = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vsync,
  input  logic        render_done,
  output logic        render_ack,
  input  logic        rend_we,
  input  logic [8:0]  rend_x,
  input  logic [7:0]  rend_y,
  input  logic [2:0]  rend_color,
  output logic        fb_we,
  output logic [8:0]  fb_x,
  output logic [7:0]  fb_y,
  output logic [2:0]  fb_color,
  output logic        fb_sel,
  output logic        display_sel,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_count,
  output logic        oob_err,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] CLEAR      = 3'd0;
  localparam logic [2:0] START      = 3'd1;
  localparam logic [2:0] RENDER     = 3'd2;
  localparam logic [2:0] WAIT_VSYNC = 3'd3;
  localparam logic [2:0] SWAP       = 3'd4;

  localparam logic [8:0] X_MAX = 9'd319;
  localparam logic [7:0] Y_MAX = 8'd239;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [8:0] clr_x;
  logic [7:0] clr_y;
  logic       clr_last;
  logic       rend_in_range;
  logic       overrun_hit;

  assign clr_last      = (clr_x == X_MAX) && (clr_y == Y_MAX);
  assign rend_in_range = (rend_x <= X_MAX) && (rend_y <= Y_MAX);

  // A vsync is missed whenever the back buffer is not ready, except when the
  // renderer finishes in the very same cycle (that case swaps directly).
  assign overrun_hit = vsync &&
                       ((state == CLEAR) || (state == START) ||
                        ((state == RENDER) && !render_done));

  assign render_ack  = (state == START);
  assign display_sel = ~fb_sel;
  assign dbg_state   = state;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:      if (!CLEAR_EN || clr_last) state_nxt = START;
      START:      state_nxt = RENDER;
      RENDER: begin
        if (render_done && vsync) state_nxt = SWAP;
        else if (render_done)     state_nxt = WAIT_VSYNC;
      end
      WAIT_VSYNC: if (vsync) state_nxt = SWAP;
      SWAP:       state_nxt = CLEAR;
      default:    state_nxt = CLEAR;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= CLEAR;
    else          state <= state_nxt;
  end

  // Clear-pass raster counters: x inner, y outer; rewound at the end and on swap
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_x <= '0;
      clr_y <= '0;
    end else if (state == SWAP) begin
      clr_x <= '0;
      clr_y <= '0;
    end else if (CLEAR_EN && (state == CLEAR)) begin
      if (clr_x == X_MAX) begin
        clr_x <= '0;
        clr_y <= (clr_y == Y_MAX) ? 8'd0 : clr_y + 8'd1;
      end else begin
        clr_x <= clr_x + 9'd1;
      end
    end
  end

  // Registered framebuffer write port; address/colour hold when not writing
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fb_we    <= 1'b0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= '0;
    end else if (CLEAR_EN && (state == CLEAR)) begin
      fb_we    <= 1'b1;
      fb_x     <= clr_x;
      fb_y     <= clr_y;
      fb_color <= SKY_COLOR;
    end else if ((state == RENDER) && rend_we && rend_in_range) begin
      fb_we    <= 1'b1;
      fb_x     <= rend_x;
      fb_y     <= rend_y;
      fb_color <= rend_color;
    end else begin
      fb_we    <= 1'b0;
    end
  end

  // Sticky flag for renderer writes that fell outside the 320x240 buffer
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                                         oob_err <= 1'b0;
    else if ((state == RENDER) && rend_we && !rend_in_range) oob_err <= 1'b1;
  end

  // Buffer select and completed-frame counter advance together on swap
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fb_sel      <= 1'b1;
      frame_count <= '0;
    end else if (state == SWAP) begin
      fb_sel      <= ~fb_sel;
      frame_count <= frame_count + 16'd1;
    end
  end

  // Saturating count of vsyncs that arrived before the back buffer was ready
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                             overrun_count <= '0;
    else if (overrun_hit && (overrun_count != 8'hFF)) overrun_count <= overrun_count + 8'd1;
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: scoreboard bench for frame_scheduler.
// dut_a (clear enabled) covers the full clear pass, render forwarding, swap
// and mid-clear reset; dut_b (clear disabled) covers swap ordering, overrun
// saturation and mid-render reset without paying for extra clear passes.
module tb_frame_scheduler;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // dut_a signals
  logic Reset_n_a, vsync_a, render_done_a, render_ack_a, rend_we_a;
  logic [8:0] rend_x_a;  logic [7:0] rend_y_a;  logic [2:0] rend_color_a;
  logic fb_we_a;  logic [8:0] fb_x_a;  logic [7:0] fb_y_a;  logic [2:0] fb_color_a;
  logic fb_sel_a, display_sel_a, oob_err_a;
  logic [15:0] frame_count_a;  logic [7:0] overrun_count_a;  logic [2:0] dbg_state_a;

  // dut_b signals
  logic Reset_n_b, vsync_b, render_done_b, render_ack_b, rend_we_b;
  logic [8:0] rend_x_b;  logic [7:0] rend_y_b;  logic [2:0] rend_color_b;
  logic fb_we_b;  logic [8:0] fb_x_b;  logic [7:0] fb_y_b;  logic [2:0] fb_color_b;
  logic fb_sel_b, display_sel_b, oob_err_b;
  logic [15:0] frame_count_b;  logic [7:0] overrun_count_b;  logic [2:0] dbg_state_b;

  frame_scheduler #(.SKY_COLOR(3'd1), .CLEAR_EN(1'b1)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n_a), .vsync(vsync_a), .render_done(render_done_a),
    .render_ack(render_ack_a), .rend_we(rend_we_a), .rend_x(rend_x_a), .rend_y(rend_y_a),
    .rend_color(rend_color_a), .fb_we(fb_we_a), .fb_x(fb_x_a), .fb_y(fb_y_a),
    .fb_color(fb_color_a), .fb_sel(fb_sel_a), .display_sel(display_sel_a),
    .frame_count(frame_count_a), .overrun_count(overrun_count_a), .oob_err(oob_err_a),
    .dbg_state(dbg_state_a)
  );

  frame_scheduler #(.SKY_COLOR(3'd1), .CLEAR_EN(1'b0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n_b), .vsync(vsync_b), .render_done(render_done_b),
    .render_ack(render_ack_b), .rend_we(rend_we_b), .rend_x(rend_x_b), .rend_y(rend_y_b),
    .rend_color(rend_color_b), .fb_we(fb_we_b), .fb_x(fb_x_b), .fb_y(fb_y_b),
    .fb_color(fb_color_b), .fb_sel(fb_sel_b), .display_sel(display_sel_b),
    .frame_count(frame_count_b), .overrun_count(overrun_count_b), .oob_err(oob_err_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {x[8:0], y[7:0], color[2:0]}
  logic [19:0] exp_a[$];
  logic [19:0] exp_b[$];
  logic        mon_en_a = 1'b0;
  int          wr_cnt_a = 0;

  function automatic logic [19:0] pix(input int x, input int y, input int c);
    logic [8:0] px;  logic [7:0] py;  logic [2:0] pc;
    px = 9'(x);  py = 8'(y);  pc = 3'(c);
    return {px, py, pc};
  endfunction

  // Monitor for dut_a writes
  always @(negedge Clk) begin
    if (mon_en_a && fb_we_a) begin
      logic [19:0] got;
      logic [19:0] exp;
      got = {fb_x_a, fb_y_a, fb_color_a};
      wr_cnt_a++;
      n_cmp++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a_unexpected: got x=%0d y=%0d c=%0d, required no write",
                 fb_x_a, fb_y_a, fb_color_a);
      end else begin
        exp = exp_a.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sb_a_write: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                   got[19:11], got[10:3], got[2:0], exp[19:11], exp[10:3], exp[2:0]);
        end
      end
    end
  end

  // Monitor for dut_b writes (clear disabled, renderer never writes in RENDER here)
  always @(negedge Clk) begin
    if (fb_we_b) begin
      logic [19:0] got;
      logic [19:0] exp;
      got = {fb_x_b, fb_y_b, fb_color_b};
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b_unexpected: got x=%0d y=%0d c=%0d, required no write",
                 fb_x_b, fb_y_b, fb_color_b);
      end else begin
        exp = exp_b.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sb_b_write: got %0h, required %0h", got, exp);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drain_a(input string name, input int budget);
    int k;
    k = 0;
    while (exp_a.size() != 0 && k < budget) begin
      @(posedge Clk);
      #2;
      k++;
    end
    chk(name, exp_a.size(), 0);
  endtask

  task automatic wait_ack_b(input string name);
    int k;
    k = 0;
    while (!render_ack_b && k < 10) begin
      tick();
      k++;
    end
    chk(name, render_ack_b, 1);
    tick();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_state"}, dbg_state_a, 0);
    chk({tag, "_fb_sel"}, fb_sel_a, 1);
    chk({tag, "_display_sel"}, display_sel_a, 0);
    chk({tag, "_frame"}, frame_count_a, 0);
    chk({tag, "_overrun"}, overrun_count_a, 0);
    chk({tag, "_oob"}, oob_err_a, 0);
    chk({tag, "_ack"}, render_ack_a, 0);
    chk({tag, "_fb_we"}, fb_we_a, 0);
    chk({tag, "_fb_xyc"}, {fb_x_a, fb_y_a, fb_color_a}, 0);
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, "_state"}, dbg_state_b, 0);
    chk({tag, "_fb_sel"}, fb_sel_b, 1);
    chk({tag, "_display_sel"}, display_sel_b, 0);
    chk({tag, "_frame"}, frame_count_b, 0);
    chk({tag, "_overrun"}, overrun_count_b, 0);
    chk({tag, "_oob"}, oob_err_b, 0);
    chk({tag, "_ack"}, render_ack_b, 0);
    chk({tag, "_fb_we"}, fb_we_b, 0);
    chk({tag, "_fb_xyc"}, {fb_x_b, fb_y_b, fb_color_b}, 0);
  endtask

  // Hard stop in case some wait is not bounded by its own budget
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, required completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    Reset_n_a = 1'b0;  vsync_a = 1'b0;  render_done_a = 1'b0;  rend_we_a = 1'b0;
    rend_x_a = '0;  rend_y_a = '0;  rend_color_a = '0;
    Reset_n_b = 1'b0;  vsync_b = 1'b0;  render_done_b = 1'b0;  rend_we_b = 1'b0;
    rend_x_b = '0;  rend_y_b = '0;  rend_color_b = '0;

    repeat (3) tick();
    chk_reset_a("a_por");
    chk_reset_b("b_por");

    // ---- dut_a: full clear pass ----
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++)
        exp_a.push_back(pix(x, y, 1));
    mon_en_a  = 1'b1;
    Reset_n_a = 1'b1;
    k = 0;
    while (!render_ack_a && k < 80000) begin
      tick();
      k++;
    end
    chk("a_clear_len_to_ack", k, 76800);
    chk("a_ack_seen", render_ack_a, 1);
    tick();
    chk("a_ack_one_cycle", render_ack_a, 0);
    chk("a_clear_writes", wr_cnt_a, 76800);
    chk("a_clear_queue", exp_a.size(), 0);
    chk("a_render_state", dbg_state_a, 2);

    // ---- dut_a: renderer forwarding and out-of-range drop ----
    rend_we_a = 1'b1;  rend_x_a = 9'd10;  rend_y_a = 8'd20;  rend_color_a = 3'd5;
    exp_a.push_back(pix(10, 20, 5));
    tick();
    chk("a_oob_clean", oob_err_a, 0);
    rend_x_a = 9'd320;  rend_y_a = 8'd5;  rend_color_a = 3'd3;
    tick();
    chk("a_oob_x_dropped", fb_we_a, 0);
    chk("a_oob_x_set", oob_err_a, 1);
    rend_x_a = 9'd319;  rend_y_a = 8'd239;  rend_color_a = 3'd7;
    exp_a.push_back(pix(319, 239, 7));
    tick();
    rend_x_a = 9'd0;  rend_y_a = 8'd240;  rend_color_a = 3'd2;
    tick();
    rend_we_a = 1'b0;
    tick();
    chk("a_oob_sticky", oob_err_a, 1);
    chk("a_hold_xyc", {fb_x_a, fb_y_a, fb_color_a}, {9'd319, 8'd239, 3'd7});
    chk("a_render_queue", exp_a.size(), 0);

    // ---- dut_a: render_done, vsync 100 cycles later, swap ----
    render_done_a = 1'b1;
    tick();
    render_done_a = 1'b0;
    chk("a_wait_state", dbg_state_a, 3);
    repeat (100) tick();
    chk("a_no_early_swap", fb_sel_a, 1);
    vsync_a = 1'b1;
    tick();
    vsync_a = 1'b0;
    chk("a_swap_state", dbg_state_a, 4);
    tick();
    chk("a_swap_fb_sel", fb_sel_a, 0);
    chk("a_swap_display_sel", display_sel_a, 1);
    chk("a_swap_frame", frame_count_a, 1);
    chk("a_swap_overrun", overrun_count_a, 0);
    chk("a_swap_oob_kept", oob_err_a, 1);
    for (int x = 0; x < 4; x++) exp_a.push_back(pix(x, 0, 1));
    drain_a("a_clear_restart", 10);

    // ---- dut_a: reset mid-clear, then clear restarts at (0,0) ----
    Reset_n_a = 1'b0;
    #1;
    chk_reset_a("a_mid_clear_rst");
    for (int x = 0; x < 3; x++) exp_a.push_back(pix(x, 0, 1));
    Reset_n_a = 1'b1;
    drain_a("a_clear_after_rst", 10);
    mon_en_a = 1'b0;

    // ---- dut_b: clear disabled goes straight to START ----
    tick();
    Reset_n_b = 1'b1;
    tick();
    chk("b_start_ack", render_ack_b, 1);
    chk("b_no_clear_write", fb_we_b, 0);
    tick();
    chk("b_render_ack_low", render_ack_b, 0);
    chk("b_render_state", dbg_state_b, 2);

    // vsync while rendering counts an overrun and does not swap
    vsync_b = 1'b1;
    tick();
    vsync_b = 1'b0;
    chk("b_overrun_1", overrun_count_b, 1);
    chk("b_no_swap_on_overrun", fb_sel_b, 1);

    // render_done and vsync together: swap next cycle, no overrun
    render_done_b = 1'b1;  vsync_b = 1'b1;
    tick();
    render_done_b = 1'b0;  vsync_b = 1'b0;
    chk("b_same_cycle_swap_state", dbg_state_b, 4);
    chk("b_same_cycle_overrun", overrun_count_b, 1);
    tick();
    chk("b_swap1_frame", frame_count_b, 1);
    chk("b_swap1_fb_sel", fb_sel_b, 0);
    chk("b_swap1_display_sel", display_sel_b, 1);
    wait_ack_b("b_ack_2");

    // second frame: renderer writes and render_done ignored while waiting
    render_done_b = 1'b1;
    tick();
    render_done_b = 1'b0;
    rend_we_b = 1'b1;  rend_x_b = 9'd5;  rend_y_b = 8'd5;  rend_color_b = 3'd6;
    tick();
    tick();
    rend_we_b = 1'b0;
    render_done_b = 1'b1;
    tick();
    render_done_b = 1'b0;
    chk("b_wait_hold", dbg_state_b, 3);
    chk("b_wait_frame", frame_count_b, 1);
    chk("b_wait_no_write", fb_we_b, 0);
    // vsync held across the SWAP cycle: second pulse must be ignored
    vsync_b = 1'b1;
    tick();
    tick();
    vsync_b = 1'b0;
    chk("b_swap2_frame", frame_count_b, 2);
    chk("b_swap2_overrun", overrun_count_b, 1);
    chk("b_swap2_fb_sel", fb_sel_b, 1);
    wait_ack_b("b_ack_3");

    // third frame
    render_done_b = 1'b1;
    tick();
    render_done_b = 1'b0;
    vsync_b = 1'b1;
    tick();
    vsync_b = 1'b0;
    tick();
    chk("b_swap3_frame", frame_count_b, 3);
    chk("b_swap3_display_sel", display_sel_b, 1);
    wait_ack_b("b_ack_4");

    // 300 vsyncs while rendering: saturate at 255, no swap
    for (int i = 0; i < 300; i++) begin
      vsync_b = 1'b1;
      tick();
      vsync_b = 1'b0;
      tick();
    end
    chk("b_overrun_sat", overrun_count_b, 255);
    chk("b_sat_display_sel", display_sel_b, 1);
    chk("b_sat_frame", frame_count_b, 3);
    chk("b_sat_state", dbg_state_b, 2);

    // reset mid-render with frame_count = 3
    Reset_n_b = 1'b0;
    #1;
    chk_reset_b("b_mid_render_rst");
    tick();
    Reset_n_b = 1'b1;
    wait_ack_b("b_ack_after_rst");
    chk("b_after_rst_frame", frame_count_b, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter SKY_COLOR, default 3'd1, colour written to every back-buffer pixel during clear.
REQ-002 SHALL have parameter CLEAR_EN, default 1; when 0 the clear pass is skipped.
REQ-003 SHALL have port Clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port vsync  in  1  one-cycle pulse at start of vertical blank.
REQ-006 SHALL have port render_done  in  1  one-cycle pulse from the renderer when a frame is complete.
REQ-007 SHALL have port render_ack  out  1  one-cycle pulse that starts a renderer frame.
REQ-008 SHALL have ports rend_we / rend_x / rend_y / rend_color  in  1/9/8/3  renderer pixel write.
REQ-009 SHALL have ports fb_we / fb_x / fb_y / fb_color  out  1/9/8/3  registered framebuffer write port.
REQ-010 SHALL have port fb_sel  out  1  buffer currently being written.
REQ-011 SHALL have port display_sel  out  1  buffer being scanned out; always ~fb_sel.
REQ-012 SHALL have port frame_count  out  16  completed swaps, wraps modulo 2^16.
REQ-013 SHALL have port overrun_count  out  8  vsyncs missed while not ready, saturating at 255.
REQ-014 SHALL have port oob_err  out  1  sticky flag for a dropped out-of-range renderer write.

Function
REQ-015 SHALL implement states CLEAR, START, RENDER, WAIT_VSYNC, SWAP.
REQ-016 CLEAR: one pixel per cycle, fb_we=1, fb_color=SKY_COLOR; x 0..319 inner, y 0..239 outer; 76800 cycles; after (319,239) -> START.
REQ-017 CLEAR with CLEAR_EN=0 SHALL pass straight to START with fb_we=0.
REQ-018 START SHALL hold render_ack=1 for exactly one cycle and then go to RENDER; render_ack SHALL be 0 in every other state.
REQ-019 RENDER SHALL forward rend_* to fb_* with 1-cycle latency when rend_we=1, rend_x<=319 and rend_y<=239.
REQ-020 In RENDER, a write with rend_x>319 or rend_y>239 SHALL be dropped (fb_we=0) and SHALL set oob_err.
REQ-021 rend_we SHALL be ignored outside RENDER, and fb_we SHALL be 0 in START, WAIT_VSYNC and SWAP.
REQ-022 render_done in RENDER SHALL move the block to WAIT_VSYNC; render_done in any other state SHALL be ignored.
REQ-023 render_done and vsync in the same RENDER cycle SHALL go directly to SWAP, with no overrun counted.
REQ-024 WAIT_VSYNC SHALL move to SWAP on vsync.
REQ-025 vsync in CLEAR, START or RENDER (except REQ-023) SHALL increment overrun_count (saturating) and SHALL NOT swap.
REQ-026 SWAP (one cycle) SHALL toggle fb_sel and display_sel, increment frame_count, reset the clear counters to (0,0), and go to CLEAR.
REQ-027 vsync in the SWAP cycle SHALL be ignored.
REQ-028 fb_x/fb_y/fb_color SHALL hold their last values when fb_we=0.

Reset
REQ-029 Asserting Reset_n=0 at any time, including mid-clear or mid-render, SHALL immediately force state=CLEAR, clear counters=(0,0), fb_sel=1, display_sel=0, frame_count=0, overrun_count=0, oob_err=0, render_ack=0, fb_we=0, fb_x=0, fb_y=0, fb_color=0.
REQ-030 After Reset_n is deasserted, the first CLEAR pixel write SHALL appear on the first rising edge on which Reset_n=1.

Verification
REQ-031 Scenario: release reset, no vsync -> fb_we=1 for exactly 76800 cycles covering (0,0)..(319,239) with colour 1, then render_ack pulses once.
REQ-032 Scenario: in RENDER drive rend_we=1 at (10,20) colour 5, then at (320,5) -> fb write (10,20,5) one cycle later, no write for the second, oob_err=1.
REQ-033 Scenario: render_done, then vsync 100 cycles later -> SWAP; fb_sel 1->0, display_sel 0->1, frame_count=1, CLEAR restarts at (0,0).
REQ-034 Scenario: render_done and vsync in the same cycle -> SWAP on the next cycle, overrun_count unchanged.
REQ-035 Scenario: 300 vsync pulses during CLEAR/RENDER -> overrun_count saturates at 255, display_sel unchanged.
REQ-036 Scenario: Reset_n low mid-RENDER with frame_count=3 -> all outputs at REQ-029 values within the same cycle, and the clear pass restarts after release.
